// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the IF stage: stall encoding, bus widths and the fetch FSM states.
// The fetch state is a 2-bit enum so it can be probed hierarchically as a plain vector.
package if_fetch_unit_pkg;

    localparam int          STALL_BUS        = 6;
    localparam logic        STOP             = 1'b1;
    localparam logic        NO_STOP          = 1'b0;
    localparam int          IF_TO_ID_WD      = 33;
    localparam int          BR_WD            = 33;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, runs one outstanding request/addr_ok/data_ok SRAM fetch at a time,
// hands {ce, pc} + instruction to ID and applies branch redirects after the delay slot.
//
// Handshakes: inst_sram_req stays high with a stable address until inst_sram_addr_ok is seen;
// data_ok is only honoured in S_WAIT. Towards ID, ce marks a valid instruction and it is
// consumed in any cycle where ce=1 and stall[0] is not Stop.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          STALL_W  = STALL_BUS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic [31:0]            if_inst,
    output logic                   inst_sram_req,
    output logic [31:0]            inst_sram_addr,
    input  logic                   inst_sram_addr_ok,
    input  logic                   inst_sram_data_ok,
    input  logic [31:0]            inst_sram_rdata,
    output logic                   stallreq_from_if
);

    if_state_e   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] br_target_q, br_target_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic        br_pend_q, br_pend_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic        stall_if;
    logic        stall_id;
    logic        unused_stall_bits;

    logic        ce;
    logic        req;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        consume;
    logic        br_cap;

    assign {br_e, br_addr}   = br_bus;
    assign stall_if          = stall[0];
    assign stall_id          = stall[1];
    assign unused_stall_bits = ^stall[STALL_W-1:2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            br_pend_q   <= 1'b0;
            br_target_q <= '0;
            hold_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            br_pend_q   <= br_pend_d;
            br_target_q <= br_target_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        br_pend_d   = br_pend_q;
        br_target_d = br_target_q;
        hold_inst_d = hold_inst_q;
        ce          = 1'b0;
        req         = 1'b0;
        pc_out      = '0;
        inst_out    = '0;

        case (state_q)
            S_REQ: begin
                // A raised request is never withdrawn, stall or not; stray data_ok is ignored here.
                req = 1'b1;
                if (inst_sram_addr_ok) begin
                    state_d  = S_WAIT;
                    req_pc_d = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    ce       = 1'b1;
                    pc_out   = req_pc_q;
                    inst_out = inst_sram_rdata;
                    if (stall_if == STOP) begin
                        hold_inst_d = inst_sram_rdata;
                        state_d     = S_HOLD;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                ce       = 1'b1;
                pc_out   = req_pc_q;
                inst_out = hold_inst_q;
                if (stall_if == NO_STOP) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        consume = ce && (stall_if == NO_STOP);
        br_cap  = br_e && (stall_id == NO_STOP) && !br_pend_q;

        // The first instruction consumed at or after branch capture is the delay slot.
        if (consume) begin
            if (br_pend_q) begin
                fetch_pc_d = br_target_q;
                br_pend_d  = 1'b0;
            end else if (br_cap) begin
                fetch_pc_d = br_addr;
            end else begin
                fetch_pc_d = req_pc_q + PC_STEP;
            end
        end else if (br_cap) begin
            br_pend_d   = 1'b1;
            br_target_d = br_addr;
        end
    end

    assign inst_sram_req    = rst & req;
    assign inst_sram_addr   = rst ? fetch_pc_q : 32'd0;
    assign if_to_id_bus     = rst ? {ce, pc_out} : '0;
    assign if_inst          = rst ? inst_out : 32'd0;
    assign stallreq_from_if = rst & ~ce;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, back-to-back fetch, stall hold, branch delay slot,
// SRAM backpressure with stray data, reset mid-transaction, and PC wrap on a second instance.
module tb_if_fetch_unit;

  localparam logic [31:0] PAT = 32'h5A5A_5A5A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [32:0] if_to_id_bus;
  logic [31:0] if_inst;
  logic        req;
  logic [31:0] addr;
  logic        stallreq;
  logic        ce_o;
  logic [31:0] pc_o;

  assign ce_o = if_to_id_bus[32];
  assign pc_o = if_to_id_bus[31:0];

  if_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .br_bus            (br_bus),
    .if_to_id_bus      (if_to_id_bus),
    .if_inst           (if_inst),
    .inst_sram_req     (req),
    .inst_sram_addr    (addr),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata),
    .stallreq_from_if  (stallreq)
  );

  // second instance starting just below the top of the address space
  logic [5:0]  w_stall;
  logic [32:0] w_br_bus;
  logic [32:0] w_bus;
  logic [31:0] w_inst;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_addr_ok;
  logic        w_data_ok;
  logic [31:0] w_rdata;
  logic        w_stallreq;

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk               (clk),
    .rst               (rst),
    .stall             (w_stall),
    .br_bus            (w_br_bus),
    .if_to_id_bus      (w_bus),
    .if_inst           (w_inst),
    .inst_sram_req     (w_req),
    .inst_sram_addr    (w_addr),
    .inst_sram_addr_ok (w_addr_ok),
    .inst_sram_data_ok (w_data_ok),
    .inst_sram_rdata   (w_rdata),
    .stallreq_from_if  (w_stallreq)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];       // {pc, inst} expected at ID
  logic [31:0] exp_addr_q[$];  // addresses expected to be accepted by the SRAM

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- SRAM model (auto mode: addr_ok from aok_en, data one cycle later) ----------------
  logic        aok_en, spur, man;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;

  always @(negedge clk) begin
    if (!man && rst && req && addr_ok) begin
      pend  = 1'b1;
      paddr = addr;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!man) begin
      data_ok = pend | spur;
      rdata   = pend ? (paddr ^ PAT) : 32'hDEAD_BEEF;
      addr_ok = aok_en;
      pend    = 1'b0;
      spur    = 1'b0;
    end
  end

  // wrap-instance SRAM: always ready, data next cycle equal to the address
  logic        w_pend = 1'b0;
  logic [31:0] w_paddr = '0;
  logic [31:0] w_rec[4];
  int          w_n = 0;

  assign w_addr_ok = 1'b1;

  always @(negedge clk) begin
    if (rst && w_req) begin
      if (w_n < 4) w_rec[w_n] = w_addr;
      w_n++;
      w_pend  = 1'b1;
      w_paddr = w_addr;
    end
  end

  always @(posedge clk) begin
    #1;
    w_data_ok = w_pend;
    w_rdata   = w_paddr;
    w_pend    = 1'b0;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst && req && addr_ok) begin
      if (exp_addr_q.size() == 0) unexpected("req_accept", 64'(addr));
      else check("req_addr", 64'(addr), 64'(exp_addr_q.pop_front()));
    end
    if (ce_o) begin
      if (exp_q.size() == 0) begin
        unexpected("id_out", {pc_o, if_inst});
      end else begin
        check("id_pc_inst", {pc_o, if_inst}, exp_q[0]);
        if (stall[0] == 1'b0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pcs[6];
    rst = 1'b0; stall = '0; br_bus = '0;
    aok_en = 1'b1; spur = 1'b0; man = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    w_stall = '0; w_br_bus = '0; w_data_ok = 1'b0; w_rdata = '0;

    pcs[0] = 32'hBFC0_0000; pcs[1] = 32'hBFC0_0004; pcs[2] = 32'hBFC0_0008;
    pcs[3] = 32'hBFC0_0100; pcs[4] = 32'hBFC0_0200; pcs[5] = 32'hBFC0_0204;
    for (int i = 0; i < 6; i++) begin
      exp_addr_q.push_back(pcs[i]);
      exp_q.push_back({pcs[i], pcs[i] ^ PAT});
    end
    exp_addr_q.push_back(32'hBFC0_0208);

    // reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_req", 64'(req), 64'd0);
      check("rst_ce", 64'(ce_o), 64'd0);
      check("rst_stallreq", 64'(stallreq), 64'd0);
    end
    step(); rst = 1'b1;
    @(negedge clk);
    check("first_req", 64'(req), 64'd1);
    check("first_addr", 64'(addr), 64'h0000_0000_BFC0_0000);

    // back-to-back cadence
    @(negedge clk);
    check("b2b_ce0", 64'(ce_o), 64'd1);
    check("b2b_pc0", 64'(pc_o), 64'h0000_0000_BFC0_0000);
    check("wrap_pc0", 64'(w_bus[31:0]), 64'h0000_0000_FFFF_FFFC);
    @(negedge clk);
    check("b2b_gap_ce", 64'(ce_o), 64'd0);
    check("b2b_addr1", 64'(addr), 64'h0000_0000_BFC0_0004);

    // stall hold starting at the data_ok of 0xBFC00004
    step(); stall = 6'b000001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_ce", 64'(ce_o), 64'd1);
      check("hold_pc", 64'(pc_o), 64'h0000_0000_BFC0_0004);
      check("hold_no_req", 64'(req), 64'd0);
      step();
    end
    stall = '0;

    // branch captured while 0xBFC00008 is requested; 08 is the delay slot
    step(); br_bus = {1'b1, 32'hBFC0_0100};
    @(negedge clk);
    check("slot_req_addr", 64'(addr), 64'h0000_0000_BFC0_0008);
    step(); br_bus = '0;
    @(negedge clk);
    check("slot_ce", 64'(ce_o), 64'd1);
    check("slot_pc", 64'(pc_o), 64'h0000_0000_BFC0_0008);
    step();
    @(negedge clk);
    check("target_req", 64'(req), 64'd1);
    check("target_addr", 64'(addr), 64'h0000_0000_BFC0_0100);

    // branch captured in the same cycle its delay slot (0x100) is consumed
    step(); br_bus = {1'b1, 32'hBFC0_0200};
    step(); br_bus = '0;
    @(negedge clk);
    check("same_cycle_br_addr", 64'(addr), 64'h0000_0000_BFC0_0200);
    aok_en = 1'b0;

    // backpressure with a stray data_ok in S_REQ
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req", 64'(req), 64'd1);
      check("bp_addr", 64'(addr), 64'h0000_0000_BFC0_0204);
      check("bp_ce", 64'(ce_o), 64'd0);
      check("bp_stallreq", 64'(stallreq), 64'd1);
      if (i == 1) spur = 1'b1;
      if (i == 4) aok_en = 1'b1;
    end
    @(negedge clk);
    man = 1'b1;

    // manual SRAM: deliver 0x204, accept 0x208, then reset while waiting on it
    step(); data_ok = 1'b1; rdata = 32'hBFC0_0204 ^ PAT; addr_ok = 1'b0;
    step(); data_ok = 1'b0; addr_ok = 1'b1;
    step(); addr_ok = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("midrst_req", 64'(req), 64'd0);
    check("midrst_ce", 64'(ce_o), 64'd0);
    check("midrst_stallreq", 64'(stallreq), 64'd0);
    step(); rst = 1'b1; data_ok = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk);
    check("stale_ce", 64'(ce_o), 64'd0);
    check("stale_req", 64'(req), 64'd1);
    check("stale_addr", 64'(addr), 64'h0000_0000_BFC0_0000);
    check("stale_stallreq", 64'(stallreq), 64'd1);
    step(); data_ok = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ce", 64'(ce_o), 64'd0);
    end

    // wrap instance: second fetch address wraps to zero
    check("wrap_count_ok", 64'(w_n >= 2), 64'd1);
    check("wrap_addr0", 64'(w_rec[0]), 64'h0000_0000_FFFF_FFFC);
    check("wrap_addr1", 64'(w_rec[1]), 64'h0000_0000_0000_0000);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp_addr_q_drained", 64'(exp_addr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline. It is the producer end of the IF->ID bus and the consumer of the branch bus resolved in ID.
- Owns the PC and drives a request/address-ok/data-ok instruction SRAM interface, with at most one transaction outstanding.
- Presents each fetched instruction with its PC to ID, buffering it across stalls.
- Applies branch redirects after the delay slot.

Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first fetch after reset.
- STALL_W, `StallBus (6), width of the stall vector.

Ports:
- clk  in  1  pipeline clock; all state changes on posedge.
- rst  in  1  reset; synchronous, active-low (rst==0 resets on posedge clk).
- stall  in  STALL_W  pipeline stall vector; stall[0]==`Stop freezes IF, stall[1]==`Stop freezes ID.
- br_bus  in  33  {br_e, br_addr[31:0]} from ID, combinational, qualified by stall[1]==`NoStop.
- if_to_id_bus  out  33  {ce, pc[31:0]}; ce=1 marks a valid instruction.
- if_inst  out  32  instruction word paired with if_to_id_bus.pc.
- inst_sram_req  out  1  fetch request.
- inst_sram_addr  out  32  fetch address; held stable while req=1 and addr_ok=0.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  read data valid this cycle.
- inst_sram_rdata  in  32  read data.
- stallreq_from_if  out  1  no instruction is available for ID this cycle.

Behaviour:
- Reset (rst==0 at posedge):
  - state=S_REQ, fetch_pc=RESET_PC, br_pend=0, br_target=0, hold_inst=0.
  - All outputs read 0 while rst==0: req=0, ce=0, pc=0, if_inst=0, stallreq_from_if=0.
  - The first req appears in the cycle after rst returns to 1.
- State machine (2-bit state: S_REQ, S_WAIT, S_HOLD):
  - S_REQ: req=1, addr=fetch_pc. If addr_ok, go to S_WAIT and latch req_pc=fetch_pc. Otherwise stay, with addr and req held.
  - S_WAIT: req=0. On data_ok, capture rdata. If stall[0]==`NoStop, the instruction is consumed this cycle and the state goes to S_REQ. Otherwise it is written to hold_inst and the state goes to S_HOLD.
  - S_HOLD: req=0, ce=1, if_inst=hold_inst, pc=req_pc. When stall[0]==`NoStop the instruction is consumed and the state goes to S_REQ.
- Output valid (ce=1) in two cases:
  - S_WAIT with data_ok: if_inst=rdata, combinational pass-through, 0-cycle latency from data_ok.
  - S_HOLD.
  - In every other cycle ce=0, pc=0, if_inst=0.
- stallreq_from_if = rst & ~ce.
- Next fetch_pc is computed on consumption:
  - br_pend==1 and the consumed instruction is the delay slot: fetch_pc=br_target, then br_pend clears.
  - Otherwise: fetch_pc=req_pc+4, wrapping mod 2^32 (32'hFFFF_FFFC+4 gives 0).
- Branch capture:
  - When br_e==1 and stall[1]==`NoStop, set br_pend=1 and br_target=br_addr.
  - The next instruction consumed at or after the capture cycle is the delay slot. Sequential fetch continues for exactly that one slot.
  - Capture and delay-slot consumption may happen in the same cycle. The next fetch then goes to br_addr directly and br_pend does not stay set.
  - A second br_e while br_pend==1 is ignored. ID cannot issue a branch in the delay slot.
- Stall:
  - stall[0]==`Stop in S_REQ: req and addr are held. A transaction is never withdrawn once req=1.
  - stall[0]==`Stop in S_WAIT: data_ok still completes and the instruction goes to S_HOLD.
- data_ok in S_REQ or S_HOLD has no matching transaction. It is ignored, including a stale return after a reset in mid-transaction.
- addr_ok and data_ok in the same cycle while in S_REQ: addr_ok is taken and data_ok is ignored.
- Maximum throughput is one instruction per 2 cycles (S_REQ, then S_WAIT) when the SRAM answers addr_ok in the request cycle and data_ok in the next cycle.

Decomposition:
- Shared defines header, already included by all stages: `StallBus, `Stop/`NoStop, `IF_TO_ID_WD (33), `BR_WD (33), RESET_PC.
- New localparams S_REQ/S_WAIT/S_HOLD go in the same header as `IF_STATE_*.
- No sub-module.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release. Required: req=0 and ce=0 during reset; first req=1 with addr=32'hBFC0_0000 in the cycle after release.
- Back-to-back fetch: SRAM with 0-wait addr_ok and 1-cycle data_ok returning addr^32'h5A5A_5A5A. Required: ce pulses every 2 cycles with pc 0xBFC00000, 0xBFC00004, 0xBFC00008, and if_inst matches the pattern for each pc.
- Stall hold: assert stall[0]=1 for 4 cycles starting at a data_ok for pc 0xBFC00004. Required: ce=1 with pc=0xBFC00004 and the same if_inst for all 4 cycles; no new req; after release, the next req address is 0xBFC00008.
- Branch with delay slot:
  - Stimulus: drive br_bus={1, 32'hBFC0_0100} for one cycle while the fetch for 0xBFC00008 is in flight.
  - Required: 0xBFC00008 is delivered as the delay slot; the next req address is 0xBFC00100, not 0xBFC0000C.
- Backpressure and stale data: hold addr_ok=0 for 5 cycles, injecting a spurious data_ok in S_REQ. Required: addr and req stay stable; the spurious data is dropped; ce=0 until the real data_ok arrives.
- Reset mid-transaction and PC wrap:
  - Reset mid-transaction: assert rst=0 while in S_WAIT; the stale data_ok after release must not produce ce.
  - PC wrap: with RESET_PC=32'hFFFF_FFFC, the second fetch address is 32'h0000_0000.
